decoder_ifns_10di_serial: RTL and testbench



---
 rtl/ifns_pkg.sv | 24 ++
 rtl/ifns_weight_rom.sv | 16 +
 rtl/decoder_ifns_10di_serial.sv | 121 ++++++++++++
 tb/tb_decoder_ifns_10di_serial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ifns_pkg.sv
// Shared definitions for the 10-bit IFNS crosstalk-avoidance codec.
package ifns_pkg;

  localparam int CW_W   = 14;
  localparam int DATA_W = 10;
  localparam int ACC_W  = 11;
  localparam int IDX_W  = 4;

  // Decoded values above this limit do not fit in DATA_W and are flagged
  localparam int OVF_LIMIT = 1023;

  // Weight of each codeword bit, index 0 = d1 ... index 13 = d14
  localparam logic [DATA_W-1:0] IFNS_W [0:CW_W-1] = '{
    10'd1,  10'd1,  10'd2,   10'd3,   10'd5,   10'd8,   10'd13,
    10'd21, 10'd34, 10'd55,  10'd89,  10'd144, 10'd233, 10'd610
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } ifns_state_e;

endpackage

// File: rtl/ifns_weight_rom.sv
// Combinational lookup of the weight carried by codeword bit d(idx+1).
module ifns_weight_rom
  import ifns_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] weight_o
);

  // Table lookup; indices beyond d14 carry no weight
  always_comb begin
    // NOTE: this is a constant table, not storage, so there is nothing to reset.
    if (idx_i <= IDX_W'(CW_W - 1)) weight_o = IFNS_W[idx_i];
    else                          weight_o = '0;
  end

endmodule

// File: rtl/decoder_ifns_10di_serial.sv
// Serial IFNS decoder: adds one codeword bit's weight per cycle, MSB first,
// with valid/ready handshakes on input and output.
module decoder_ifns_10di_serial
  import ifns_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CW_W - 1);

  ifns_state_e       state_q, state_d;
  logic [CW_W-1:0]   sreg_q,  sreg_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              ovf_q,   ovf_d;

  logic [DATA_W-1:0] weight;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_sum;

  ifns_weight_rom u_rom (
    .idx_i    (idx_q),
    .weight_o (weight)
  );

  // Weight contributed by the bit currently at the top of the shift register
  assign addend  = sreg_q[CW_W-1] ? ACC_W'(weight) : '0;
  assign acc_sum = acc_q + addend;

  assign out_data = data_q;
  assign out_ovf  = ovf_q;

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_cw;
          acc_d   = '0;
          idx_d   = IDX_LAST;
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        busy   = 1'b1;
        acc_d  = acc_sum;
        sreg_d = {sreg_q[CW_W-2:0], 1'b0};
        if (idx_q == '0) begin
          // Last bit (d1) folded in: publish the result
          data_d  = acc_sum[DATA_W-1:0];
          ovf_d   = (acc_sum > ACC_W'(OVF_LIMIT));
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // A new codeword may enter on the same edge the result leaves
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            sreg_d  = in_cw;
            acc_d   = '0;
            idx_d   = IDX_LAST;
            state_d = ST_ACC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      idx_q   <= IDX_LAST;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_decoder_ifns_10di_serial.sv
// Self-checking bench for the serial IFNS decoder.
module tb_decoder_ifns_10di_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_cw;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Bit weights, d1 first
  int wt [14] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 610};

  decoder_ifns_10di_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cw     (in_cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int model_sum(logic [13:0] cw);
    int s = 0;
    for (int i = 0; i < 14; i++) if (cw[i]) s += wt[i];
    return s;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns edges waited
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!out_valid && cycles < 40);
  endtask

  // Full decode with out_ready=1; called 1 time unit after a rising edge in IDLE
  task automatic run_one(string tag, logic [13:0] cw);
    int s;
    int lat;
    s = model_sum(cw);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_cw    = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cw    = 14'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd14);
    check({tag, "_data"}, 32'(out_data), 32'(s % 1024));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(s > 1023));
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [13:0] cw;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_data",      32'(out_data),  32'd0);
    check("rst_ovf",       32'(out_ovf),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed decodes
    run_one("zero",    14'h0000);
    run_one("d14",     14'b10000000000000);
    run_one("d2d1",    14'b00000000000011);
    run_one("all_one", 14'h3FFF);
    check("all_one_exp", 32'(out_data), 32'd195);

    // Backpressure: result held while the consumer stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = 14'b01000000000001;
    @(posedge clk); #1;
    in_cw = 14'h1555;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 5; i++) begin
      check("bp_data",      32'(out_data),  32'd234);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_idle",       32'(busy),      32'd0);

    // Back-to-back: second codeword enters on the first output handshake
    in_valid = 1'b1;
    in_cw    = 14'b10000000000000;
    @(posedge clk); #1;
    in_cw = 14'b01000000000000;
    wait_valid(lat);
    check("b2b_first_lat",  32'(lat),      32'd14);
    check("b2b_first_data", 32'(out_data), 32'd610);
    check("b2b_in_ready",   32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accept",     32'(busy),      32'd1);
    check("b2b_valid_drop", 32'(out_valid), 32'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_spacing",     32'(lat),      32'd15);
    check("b2b_second_data", 32'(out_data), 32'd233);
    @(posedge clk); #1;
    check("b2b_end", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of accumulation
    in_valid = 1'b1;
    in_cw    = 14'h2AAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_data",      32'(out_data),  32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_one("after_rst", 14'b00100000000000);
    check("after_rst_exp", 32'(out_data), 32'd144);

    // Randomized codewords against the weight-sum model
    for (int i = 0; i < 20; i++) begin
      cw = 14'($urandom);
      run_one("rand", cw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
